// File: rtl/cpu_multicycle_if.sv
// Unified memory port of the multicycle CPU: one req/ready channel shared by
// instruction fetch and data load/store.
interface cpu_multicycle_if #(
  parameter int N = 16
);
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle N-bit CPU with a 16-bit instruction word, 8-entry register file,
// one shared wait-state-tolerant memory port and a retired-instruction counter.
module cpu_multicycle #(
  parameter int             n        = 16,
  parameter logic [n-1:0]   RESET_PC = '0,
  parameter int             CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  cpu_multicycle_if.master   mem,
  output logic [n-1:0]       pc,
  output logic               halted,
  output logic [CNT_W-1:0]   instret
);

  localparam int SH_W = $clog2(n);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ALUWB  = 4'd4;
  localparam logic [3:0] S_MEMADR = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWB  = 4'd7;
  localparam logic [3:0] S_MEMWR  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  logic [3:0]       state_q, state_d;
  logic [n-1:0]     pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [n-1:0]     a_q, a_d;
  logic [n-1:0]     b_q, b_d;
  logic [n-1:0]     alu_q, alu_d;
  logic [n-1:0]     mdr_q, mdr_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [n-1:0]     rf_q [0:7];
  logic             rf_we;
  logic [2:0]       rf_wa;
  logic [n-1:0]     rf_wd;

  logic [2:0]       op, rs, rt, rd, funct;
  logic [n-1:0]     imm, rs_val, rt_val, alu_r;
  logic             retire, take;

  assign op     = ir_q[15:13];
  assign rs     = ir_q[12:10];
  assign rt     = ir_q[9:7];
  assign rd     = ir_q[6:4];
  assign funct  = ir_q[2:0];
  assign imm    = {{(n-7){ir_q[6]}}, ir_q[6:0]};
  assign rs_val = (rs == 3'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 3'd0) ? '0 : rf_q[rt];

  // Shift amount uses log2(n) bits of rt, i.e. rt[3:0] for the 16-bit core.
  always_comb begin
    alu_r = '0;
    case (funct)
      3'b000:  alu_r = a_q + b_q;
      3'b001:  alu_r = a_q - b_q;
      3'b010:  alu_r = a_q & b_q;
      3'b011:  alu_r = a_q | b_q;
      3'b100:  alu_r = {{(n-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b101:  alu_r = a_q ^ b_q;
      3'b110:  alu_r = a_q << b_q[SH_W-1:0];
      default: alu_r = a_q >> b_q[SH_W-1:0];
    endcase
  end

  assign take = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    halted_d = halted_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = rt;
    rf_wd    = alu_q;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata[15:0];
          pc_d    = pc_q + n'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        case (op)
          OP_R:         state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            retire   = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_d   = alu_r;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_d   = a_q + imm;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        rf_wa   = (op == OP_R) ? rd : rt;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        alu_d   = a_q + imm;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (mem.mem_ready) begin
          mdr_d   = mem.mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr_q;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        // pc already points past the branch, so this is pc_plus1 + imm
        if (take) pc_d = pc_q + imm;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[n-1:13], ir_q[12:0]};
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      halted_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  end

  // Register file is deliberately left unreset; software initialises it.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_wa != 3'd0)) rf_q[rf_wa] <= rf_wd;
  end

  // Bus outputs depend on state/registers only; gating with the reset pin
  // makes an in-flight request vanish the moment reset asserts.
  logic is_fetch, is_rd, is_wr;
  assign is_fetch = reset && (state_q == S_FETCH);
  assign is_rd    = reset && (state_q == S_MEMRD);
  assign is_wr    = reset && (state_q == S_MEMWR);

  assign mem.mem_req   = is_fetch | is_rd | is_wr;
  assign mem.mem_we    = is_wr;
  assign mem.mem_addr  = is_fetch ? pc_q : ((is_rd | is_wr) ? alu_q : '0);
  assign mem.mem_wdata = is_wr ? b_q : '0;

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench: a 16-bit core (RESET_PC=0x10, wait-state memory) and a
// 32-bit core (3-bit retire counter) run small hand-assembled programs.
module tb_cpu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16 = 1'b0;
  logic rst32 = 1'b0;

  cpu_multicycle_if #(.N(16)) if16 ();
  cpu_multicycle_if #(.N(32)) if32 ();

  logic [15:0] pc16;
  logic        halted16;
  logic [31:0] ins16;
  logic [31:0] pc32;
  logic        halted32;
  logic [2:0]  ins32;

  cpu_multicycle #(.n(16), .RESET_PC(16'h0010), .CNT_W(32)) u_cpu16 (
    .clk(clk), .reset(rst16), .mem(if16.master),
    .pc(pc16), .halted(halted16), .instret(ins16)
  );

  cpu_multicycle #(.n(32), .RESET_PC(32'h0), .CNT_W(3)) u_cpu32 (
    .clk(clk), .reset(rst32), .mem(if32.master),
    .pc(pc32), .halted(halted32), .instret(ins32)
  );

  // 16-bit memory with a programmable number of wait states
  logic [15:0] m16 [256];
  int          w16 = 0;
  int          c16 = 0;
  logic        ld16_en = 1'b0;
  logic [7:0]  ld16_a = '0;
  logic [15:0] ld16_d = '0;

  assign if16.mem_ready = if16.mem_req && (c16 == w16);
  assign if16.mem_rdata = m16[if16.mem_addr[7:0]];

  always @(posedge clk) begin
    if (ld16_en) m16[ld16_a] <= ld16_d;
    else if (if16.mem_req && if16.mem_ready && if16.mem_we)
      m16[if16.mem_addr[7:0]] <= if16.mem_wdata;
    if (if16.mem_req && !if16.mem_ready) c16 <= c16 + 1;
    else c16 <= 0;
  end

  // zero-wait 32-bit memory
  logic [31:0] m32 [64];
  logic        ld32_en = 1'b0;
  logic [5:0]  ld32_a = '0;
  logic [31:0] ld32_d = '0;

  assign if32.mem_ready = if32.mem_req;
  assign if32.mem_rdata = m32[if32.mem_addr[5:0]];

  always @(posedge clk) begin
    if (ld32_en) m32[ld32_a] <= ld32_d;
    else if (if32.mem_req && if32.mem_we) m32[if32.mem_addr[5:0]] <= if32.mem_wdata;
  end

  // read-completion log and store-to-address-4 stability monitor
  logic [15:0] rlog [64];
  int          rn = 0;
  int          w4ok = 0;
  int          w4bad = 0;

  always @(posedge clk) begin
    if (!rst16) rn <= 0;
    else if (if16.mem_req && if16.mem_ready && !if16.mem_we && rn < 64) begin
      rlog[rn] <= if16.mem_addr;
      rn       <= rn + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst16) begin
      w4ok  <= 0;
      w4bad <= 0;
    end else if (if16.mem_req && if16.mem_we && if16.mem_addr == 16'd4) begin
      if (if16.mem_wdata == 16'h1234) w4ok <= w4ok + 1;
      else w4bad <= w4bad + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int f);
    return {3'b000, 3'(rs), 3'(rt), 3'(rd), 1'b0, 3'(f)};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input int rs, input int rt, input int imm);
    return {op, 3'(rs), 3'(rt), 7'(imm)};
  endfunction

  function automatic logic [15:0] enc_j(input int t);
    return {3'b110, 13'(t)};
  endfunction

  localparam logic [15:0] HALT = 16'hE000;

  task automatic ld16(input int a, input logic [15:0] d);
    @(negedge clk);
    ld16_a  = 8'(a);
    ld16_d  = d;
    ld16_en = 1'b1;
    @(posedge clk);
    #1 ld16_en = 1'b0;
  endtask

  task automatic ld32(input int a, input logic [31:0] d);
    @(negedge clk);
    ld32_a  = 6'(a);
    ld32_d  = d;
    ld32_en = 1'b1;
    @(posedge clk);
    #1 ld32_en = 1'b0;
  endtask

  task automatic hold16();
    @(negedge clk);
    rst16 = 1'b0;
  endtask

  task automatic boot16();
    @(negedge clk);
    rst16 = 1'b1;
    #1;
  endtask

  // cyc is the 1-based cycle number (counted from reset release) in which halted is seen
  task automatic run16(input int maxc, output int cyc);
    cyc = 1;
    while (!halted16 && cyc < maxc) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("halted16", halted16, 1);
  endtask

  logic [15:0] exp_pc [8];
  int          cyc;
  logic        seen;

  initial begin
    // ---- reset state and ALU chain, zero-wait ----
    w16 = 0;
    ld16(16'h10, enc_i(3'b001, 0, 1, 5));
    ld16(16'h11, enc_i(3'b001, 0, 2, -3));
    ld16(16'h12, enc_r(1, 2, 3, 0));
    ld16(16'h13, enc_r(2, 1, 4, 4));
    ld16(16'h14, HALT);
    @(negedge clk);
    chk("rst_pc", pc16, 16'h0010);
    chk("rst_req", if16.mem_req, 0);
    chk("rst_we", if16.mem_we, 0);
    chk("rst_addr", if16.mem_addr, 0);
    chk("rst_halted", halted16, 0);
    chk("rst_instret", ins16, 0);
    boot16();
    chk("boot_req", if16.mem_req, 1);
    chk("boot_addr", if16.mem_addr, 16'h0010);
    chk("boot_we", if16.mem_we, 0);
    run16(100, cyc);
    chk("alu_cycles", cyc, 19);
    chk("alu_instret", ins16, 5);

    // ---- dump chain results plus more ALU ops (regfile survives reset) ----
    hold16();
    ld16(16'h10, enc_r(1, 2, 5, 1));
    ld16(16'h11, enc_r(1, 2, 6, 5));
    ld16(16'h12, enc_r(1, 2, 7, 2));
    ld16(16'h13, enc_i(3'b011, 0, 3, 40));
    ld16(16'h14, enc_i(3'b011, 0, 4, 41));
    ld16(16'h15, enc_i(3'b011, 0, 5, 46));
    ld16(16'h16, enc_i(3'b011, 0, 6, 47));
    ld16(16'h17, enc_i(3'b011, 0, 7, 48));
    ld16(16'h18, enc_r(1, 2, 7, 3));
    ld16(16'h19, enc_i(3'b011, 0, 7, 49));
    ld16(16'h1A, enc_r(2, 1, 7, 7));
    ld16(16'h1B, enc_i(3'b011, 0, 7, 51));
    ld16(16'h1C, HALT);
    boot16();
    run16(200, cyc);
    chk("add_r3", m16[40], 16'h0002);
    chk("slt_r4", m16[41], 16'h0001);
    chk("sub_r5", m16[46], 16'h0008);
    chk("xor_r6", m16[47], 16'hFFF8);
    chk("and_r7", m16[48], 16'h0005);
    chk("or_r7", m16[49], 16'hFFFD);
    chk("srl_r7", m16[51], 16'h07FF);
    chk("dump_instret", ins16, 13);

    // ---- store/load through 2 wait states ----
    hold16();
    w16 = 2;
    ld16(50, 16'h1234);
    ld16(4, 16'h0000);
    ld16(16'h10, enc_i(3'b010, 0, 1, 50));
    ld16(16'h11, enc_i(3'b011, 0, 1, 4));
    ld16(16'h12, enc_i(3'b010, 0, 5, 4));
    ld16(16'h13, enc_i(3'b011, 0, 5, 42));
    ld16(16'h14, HALT);
    boot16();
    run16(300, cyc);
    chk("ws_cycles", cyc, 39);
    chk("ws_mem4", m16[4], 16'h1234);
    chk("ws_lw_r5", m16[42], 16'h1234);
    chk("ws_stable_cycles", w4ok, 3);
    chk("ws_bad_cycles", w4bad, 0);
    chk("ws_instret", ins16, 5);

    // ---- branches, jump and r0 write ----
    hold16();
    w16 = 0;
    ld16(44, 16'hFFFF);
    ld16(16'h10, enc_i(3'b100, 1, 1, 2));
    ld16(16'h11, enc_i(3'b001, 0, 7, 1));
    ld16(16'h12, enc_i(3'b001, 0, 7, 2));
    ld16(16'h13, enc_i(3'b101, 1, 1, 2));
    ld16(16'h14, enc_i(3'b001, 0, 7, 3));
    ld16(16'h15, enc_j(16'h18));
    ld16(16'h16, enc_i(3'b001, 0, 7, 4));
    ld16(16'h17, HALT);
    ld16(16'h18, enc_r(1, 1, 0, 0));
    ld16(16'h19, enc_i(3'b011, 0, 7, 43));
    ld16(16'h1A, enc_i(3'b011, 0, 0, 44));
    ld16(16'h1B, HALT);
    boot16();
    run16(200, cyc);
    exp_pc = '{16'h10, 16'h13, 16'h14, 16'h15, 16'h18, 16'h19, 16'h1A, 16'h1B};
    chk("br_reads", rn, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("br_fetch%0d", i), rlog[i], exp_pc[i]);
    chk("br_r7", m16[43], 16'h0003);
    chk("br_r0", m16[44], 16'h0000);
    chk("br_pc", pc16, 16'h001C);
    chk("br_instret", ins16, 8);

    // ---- branch to itself (imm = -1) ----
    hold16();
    ld16(16'h10, enc_i(3'b100, 0, 0, -1));
    boot16();
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("loop_instret", ins16, 10);
    chk("loop_pc", pc16, 16'h0010);
    chk("loop_halted", halted16, 0);
    chk("loop_reads", rn, 10);
    chk("loop_last_fetch", rlog[9], 16'h0010);

    // ---- reset during a store wait state ----
    hold16();
    w16 = 2;
    ld16(45, 16'h0BAD);
    ld16(16'h10, enc_i(3'b011, 0, 1, 45));
    boot16();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = if16.mem_req && if16.mem_we;
    end
    chk("abort_memwr_seen", seen, 1);
    rst16 = 1'b0;
    #1;
    chk("abort_req", if16.mem_req, 0);
    chk("abort_pc", pc16, 16'h0010);
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem", m16[45], 16'h0BAD);
    chk("abort_instret", ins16, 0);
    w16 = 0;

    // ---- 32-bit core: full-width shift, sign extension, counter wrap ----
    ld32(0, {16'h0, enc_i(3'b001, 0, 1, 1)});
    ld32(1, {16'h0, enc_i(3'b001, 0, 3, 31)});
    ld32(2, {16'h0, enc_r(1, 3, 2, 6)});
    ld32(3, {16'h0, enc_i(3'b001, 0, 4, -1)});
    ld32(4, {16'h0, enc_i(3'b011, 0, 2, 40)});
    ld32(5, {16'h0, enc_i(3'b011, 0, 4, 41)});
    ld32(6, {16'h0, enc_r(2, 3, 5, 7)});
    ld32(7, {16'h0, enc_i(3'b011, 0, 5, 42)});
    ld32(8, {16'h0, HALT});
    @(negedge clk);
    rst32 = 1'b1;
    for (int i = 0; i < 200 && !halted32; i++) @(negedge clk);
    chk("w32_halted", halted32, 1);
    chk("w32_sll", m32[40], 32'h8000_0000);
    chk("w32_addi_m1", m32[41], 32'hFFFF_FFFF);
    chk("w32_srl", m32[42], 32'h0000_0001);
    chk("w32_instret_wrap", ins32, 3'd1);
    chk("w32_pc", pc32, 32'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
